// File: rtl/elevator_group_ctrl_if.sv
// rtl/elevator_group_ctrl_if.sv - button/lamp and car indicator bundle for elevator_group_ctrl
// Carries fire_recall only when ELEVATOR_FIRE_RECALL_EN is defined.
interface elevator_group_ctrl_if #(
   parameter int NUM_FLOORS = 4,
   parameter int FLOOR_W    = $clog2(NUM_FLOORS)
);
   logic [NUM_FLOORS-1:0] car_call_in;
   logic [NUM_FLOORS-1:0] hall_up_in;
   logic [NUM_FLOORS-1:0] hall_dn_in;
   logic [FLOOR_W-1:0]    floor_idx;
   logic                  door_open;
   logic                  moving;
   logic                  dir_up;
   logic [NUM_FLOORS-1:0] car_call_lamp;
   logic [NUM_FLOORS-1:0] hall_up_lamp;
   logic [NUM_FLOORS-1:0] hall_dn_lamp;
`ifdef ELEVATOR_FIRE_RECALL_EN
   logic                  fire_recall;

   modport master (
      output car_call_in, hall_up_in, hall_dn_in, fire_recall,
      input  floor_idx, door_open, moving, dir_up,
      input  car_call_lamp, hall_up_lamp, hall_dn_lamp
   );
   modport slave (
      input  car_call_in, hall_up_in, hall_dn_in, fire_recall,
      output floor_idx, door_open, moving, dir_up,
      output car_call_lamp, hall_up_lamp, hall_dn_lamp
   );
`else
   modport master (
      output car_call_in, hall_up_in, hall_dn_in,
      input  floor_idx, door_open, moving, dir_up,
      input  car_call_lamp, hall_up_lamp, hall_dn_lamp
   );
   modport slave (
      input  car_call_in, hall_up_in, hall_dn_in,
      output floor_idx, door_open, moving, dir_up,
      output car_call_lamp, hall_up_lamp, hall_dn_lamp
   );
`endif
endinterface

// File: rtl/elevator_group_ctrl.sv
// rtl/elevator_group_ctrl.sv - N-floor collective (SCAN) elevator car controller
// Optional fire recall mode is built when ELEVATOR_FIRE_RECALL_EN is defined.
module elevator_group_ctrl #(
   parameter int NUM_FLOORS    = 4,
   parameter int FLOOR_W       = $clog2(NUM_FLOORS),
   parameter int DOOR_CYCLES   = 8,
   parameter int TRAVEL_CYCLES = 4
) (
   input logic                  clk,
   input logic                  rst,
   elevator_group_ctrl_if.slave bus
);
   localparam int TW = $clog2(TRAVEL_CYCLES + 1);
   localparam int DW = $clog2(DOOR_CYCLES + 1);
   localparam logic [TW-1:0]         TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
   localparam logic [DW-1:0]         DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0]    TOP         = FLOOR_W'(NUM_FLOORS - 1);
   localparam logic [NUM_FLOORS-1:0] ONE         = NUM_FLOORS'(1);
   localparam logic [NUM_FLOORS-1:0] UP_VALID    = ~(ONE << (NUM_FLOORS - 1));
   localparam logic [NUM_FLOORS-1:0] DN_VALID    = ~ONE;

   typedef enum logic [1:0] {S_IDLE, S_DOOR_OPEN, S_MOVING} state_t;

   state_t                state_q, state_d;
   logic [FLOOR_W-1:0]    floor_q, floor_d;
   logic                  door_q, door_d;
   logic                  moving_q, moving_d;
   logic                  dir_q, dir_d;
   logic [NUM_FLOORS-1:0] car_q, car_d;
   logic [NUM_FLOORS-1:0] up_q, up_d;
   logic [NUM_FLOORS-1:0] dn_q, dn_d;
   logic [TW-1:0]         travel_q, travel_d;
   logic [DW-1:0]         dwell_q, dwell_d;

   logic [NUM_FLOORS-1:0] calls, cur_oh, nf_oh, up_in, dn_in;
   logic [NUM_FLOORS-1:0] car_set, up_set, dn_set, car_clr, up_clr, dn_clr;
   logic [FLOOR_W-1:0]    nf;
   logic                  in_door, absorb, stop_call, go_on, ahead, behind;

   function automatic logic any_above(input logic [NUM_FLOORS-1:0] v,
                                      input logic [FLOOR_W-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (i > int'(f)) r = r | v[i];
      return r;
   endfunction

   function automatic logic any_below(input logic [NUM_FLOORS-1:0] v,
                                      input logic [FLOOR_W-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (i < int'(f)) r = r | v[i];
      return r;
   endfunction

   // Ties in distance resolve upward.
   function automatic logic nearest_is_up(input logic [NUM_FLOORS-1:0] v,
                                          input logic [FLOOR_W-1:0] f);
      int du;
      int dd;
      du = NUM_FLOORS;
      dd = NUM_FLOORS;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (v[i] && i > int'(f) && (i - int'(f)) < du) du = i - int'(f);
         if (v[i] && i < int'(f) && (int'(f) - i) < dd) dd = int'(f) - i;
      end
      return du <= dd;
   endfunction

   always_comb begin
      calls  = car_q | up_q | dn_q;
      cur_oh = ONE << floor_q;
      if (dir_q) nf = (floor_q == TOP) ? floor_q : floor_q + FLOOR_W'(1);
      else       nf = (floor_q == '0)  ? floor_q : floor_q - FLOOR_W'(1);
      nf_oh  = ONE << nf;
      up_in  = bus.hall_up_in & UP_VALID;
      dn_in  = bus.hall_dn_in & DN_VALID;

      // With the door open, presses that this stop already serves are swallowed.
      in_door = (state_q == S_DOOR_OPEN);
      car_set = bus.car_call_in & ~(in_door ? cur_oh : '0);
      up_set  = up_in & ~((in_door && dir_q)  ? cur_oh : '0);
      dn_set  = dn_in & ~((in_door && !dir_q) ? cur_oh : '0);
      absorb  = |((bus.car_call_in & ~car_set) | (up_in & ~up_set) | (dn_in & ~dn_set));

      stop_call = |((car_q | (dir_q ? up_q : dn_q)) & nf_oh);
      go_on     = dir_q ? any_above(calls, nf) : any_below(calls, nf);
      ahead     = dir_q ? any_above(calls, floor_q) : any_below(calls, floor_q);
      behind    = dir_q ? any_below(calls, floor_q) : any_above(calls, floor_q);

      state_d  = state_q;
      floor_d  = floor_q;
      door_d   = door_q;
      moving_d = moving_q;
      dir_d    = dir_q;
      travel_d = travel_q;
      dwell_d  = dwell_q;
      car_clr  = '0;
      up_clr   = '0;
      dn_clr   = '0;

      case (state_q)
         S_IDLE: begin
            if (|(calls & cur_oh)) begin
               state_d = S_DOOR_OPEN;
               door_d  = 1'b1;
               dwell_d = DOOR_LOAD;
               car_clr = cur_oh;
               up_clr  = cur_oh;
               dn_clr  = cur_oh;
               if (|(up_q & cur_oh))      dir_d = 1'b1;
               else if (|(dn_q & cur_oh)) dir_d = 1'b0;
            end else if (|calls) begin
               state_d  = S_MOVING;
               moving_d = 1'b1;
               travel_d = TRAVEL_LOAD;
               if (floor_q == '0)      dir_d = 1'b1;
               else if (floor_q == TOP) dir_d = 1'b0;
               else                     dir_d = nearest_is_up(calls, floor_q);
            end
         end

         S_MOVING: begin
            if (travel_q != '0) begin
               travel_d = travel_q - TW'(1);
            end else begin
               floor_d = nf;
               if (stop_call || !go_on) begin
                  state_d  = S_DOOR_OPEN;
                  moving_d = 1'b0;
                  door_d   = 1'b1;
                  dwell_d  = DOOR_LOAD;
                  car_clr  = nf_oh;
                  if (dir_q) up_clr = nf_oh;
                  else       dn_clr = nf_oh;
                  // End of the run: turn around and serve the waiting opposite call too.
                  if (!stop_call) begin
                     dir_d  = !dir_q;
                     up_clr = nf_oh;
                     dn_clr = nf_oh;
                  end
               end else begin
                  travel_d = TRAVEL_LOAD;
               end
            end
         end

         S_DOOR_OPEN: begin
            if (absorb) begin
               dwell_d = DOOR_LOAD;
            end else if (dwell_q != '0) begin
               dwell_d = dwell_q - DW'(1);
            end else if (ahead) begin
               state_d  = S_MOVING;
               door_d   = 1'b0;
               moving_d = 1'b1;
               travel_d = TRAVEL_LOAD;
            end else if (behind) begin
               dir_d = !dir_q;
               if (|((dir_q ? dn_q : up_q) & cur_oh)) begin
                  if (dir_q) dn_clr = cur_oh;
                  else       up_clr = cur_oh;
                  dwell_d = DOOR_LOAD;
               end else begin
                  state_d  = S_MOVING;
                  door_d   = 1'b0;
                  moving_d = 1'b1;
                  travel_d = TRAVEL_LOAD;
               end
            end else begin
               state_d = S_IDLE;
               door_d  = 1'b0;
            end
         end

         default: state_d = S_IDLE;
      endcase

      car_d = (car_q | car_set) & ~car_clr;
      up_d  = (up_q | up_set) & ~up_clr;
      dn_d  = (dn_q | dn_set) & ~dn_clr;

`ifdef ELEVATOR_FIRE_RECALL_EN
      // Recall: finish any step in progress, then run non-stop to floor 0 and hold the door.
      if (bus.fire_recall) begin
         car_d    = '0;
         up_d     = '0;
         dn_d     = '0;
         state_d  = state_q;
         floor_d  = floor_q;
         door_d   = door_q;
         moving_d = moving_q;
         dir_d    = dir_q;
         travel_d = travel_q;
         dwell_d  = dwell_q;
         if (state_q == S_MOVING) begin
            if (travel_q != '0) begin
               travel_d = travel_q - TW'(1);
            end else begin
               floor_d = nf;
               dir_d   = 1'b0;
               if (nf == '0) begin
                  state_d  = S_DOOR_OPEN;
                  moving_d = 1'b0;
                  door_d   = 1'b1;
                  dwell_d  = DOOR_LOAD;
               end else begin
                  travel_d = TRAVEL_LOAD;
               end
            end
         end else if (floor_q == '0) begin
            state_d  = S_DOOR_OPEN;
            door_d   = 1'b1;
            moving_d = 1'b0;
            dir_d    = 1'b0;
            dwell_d  = DOOR_LOAD;
         end else begin
            state_d  = S_MOVING;
            door_d   = 1'b0;
            moving_d = 1'b1;
            dir_d    = 1'b0;
            travel_d = TRAVEL_LOAD;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         floor_q  <= '0;
         door_q   <= 1'b0;
         moving_q <= 1'b0;
         dir_q    <= 1'b1;
         car_q    <= '0;
         up_q     <= '0;
         dn_q     <= '0;
         travel_q <= '0;
         dwell_q  <= '0;
      end else begin
         state_q  <= state_d;
         floor_q  <= floor_d;
         door_q   <= door_d;
         moving_q <= moving_d;
         dir_q    <= dir_d;
         car_q    <= car_d;
         up_q     <= up_d;
         dn_q     <= dn_d;
         travel_q <= travel_d;
         dwell_q  <= dwell_d;
      end
   end

   assign bus.floor_idx     = floor_q;
   assign bus.door_open     = door_q;
   assign bus.moving        = moving_q;
   assign bus.dir_up        = dir_q;
   assign bus.car_call_lamp = car_q;
   assign bus.hall_up_lamp  = up_q;
   assign bus.hall_dn_lamp  = dn_q;

endmodule

// File: tb/tb_elevator_group_ctrl.sv
// tb/tb_elevator_group_ctrl.sv - directed scoreboard bench for elevator_group_ctrl
module tb_elevator_group_ctrl;
   localparam int NF = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   elevator_group_ctrl_if #(.NUM_FLOORS(NF)) bus ();

   elevator_group_ctrl #(
      .NUM_FLOORS(NF),
      .DOOR_CYCLES(8),
      .TRAVEL_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int floor;
      int dir;
   } stop_t;

   stop_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    dur;
   logic  done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_stop(input int f, input int d);
      stop_t s;
      s.floor = f;
      s.dir   = d;
      exp_q.push_back(s);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Every rising door_open is a stop; compare it against the next expected stop.
   initial begin
      logic  door_prev;
      stop_t e;
      door_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.door_open === 1'b1 && door_prev !== 1'b1) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
               n_fail++;
               $error("FAIL unexpected_stop: observed stop at floor %0d, expected none", bus.floor_idx);
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("stop_floor", 32'(bus.floor_idx), e.floor);
               check("stop_dir", 32'(bus.dir_up), e.dir);
            end
         end
         door_prev = bus.door_open;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      bus.car_call_in = '0;
      bus.hall_up_in  = '0;
      bus.hall_dn_in  = '0;
`ifdef ELEVATOR_FIRE_RECALL_EN
      bus.fire_recall = 1'b0;
`endif
      wait_edges(2);
      check("rst_floor", 32'(bus.floor_idx), 0);
      check("rst_door", 32'(bus.door_open), 0);
      check("rst_moving", 32'(bus.moving), 0);
      check("rst_dir", 32'(bus.dir_up), 1);
      check("rst_lamps", {bus.car_call_lamp, bus.hall_up_lamp, bus.hall_dn_lamp}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Car call to floor 2 from idle at floor 0: exact timeline.
      @(negedge clk);
      bus.car_call_in = 4'b0100;
      wait_edges(1);
      bus.car_call_in = '0;
      check("t1_lamp_k", 32'(bus.car_call_lamp), 4'b0100);
      check("t1_moving_k", 32'(bus.moving), 0);
      push_stop(2, 1);
      wait_edges(1);
      check("t1_moving_k1", 32'(bus.moving), 1);
      wait_edges(3);
      check("t1_floor_k4", 32'(bus.floor_idx), 0);
      wait_edges(1);
      check("t1_floor_k5", 32'(bus.floor_idx), 1);
      wait_edges(4);
      check("t1_floor_k9", 32'(bus.floor_idx), 2);
      check("t1_door_k9", 32'(bus.door_open), 1);
      check("t1_moving_k9", 32'(bus.moving), 0);
      check("t1_lamp_k9", 32'(bus.car_call_lamp), 0);
      wait_edges(7);
      check("t1_door_k16", 32'(bus.door_open), 1);
      wait_edges(1);
      check("t1_door_k17", 32'(bus.door_open), 0);
      check("t1_moving_k17", 32'(bus.moving), 0);
      wait_edges(3);
      check("t1_idle_hold", {31'd0, bus.moving | bus.door_open}, 0);

      // Hall up at own floor: door opens next edge for exactly 8 cycles.
      do_reset();
      @(negedge clk);
      bus.hall_up_in = 4'b0001;
      wait_edges(1);
      bus.hall_up_in = '0;
      check("t2_lamp_k", 32'(bus.hall_up_lamp), 4'b0001);
      push_stop(0, 1);
      wait_edges(1);
      check("t2_door_k1", 32'(bus.door_open), 1);
      check("t2_lamp_k1", 32'(bus.hall_up_lamp), 0);
      dur = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.door_open === 1'b1) dur++;
         wait_edges(1);
      end
      check("t2_door_cycles", dur, 8);

      // Collective sweep: up to 2 and 3, then back down to 1.
      @(negedge clk);
      bus.car_call_in = 4'b1000;
      wait_edges(1);
      bus.car_call_in = '0;
      push_stop(2, 1);
      push_stop(3, 1);
      push_stop(1, 0);
      wait_edges(1);
      check("t3_moving", 32'(bus.moving), 1);
      @(negedge clk);
      bus.hall_up_in = 4'b0100;
      bus.hall_dn_in = 4'b0010;
      wait_edges(1);
      bus.hall_up_in = '0;
      bus.hall_dn_in = '0;
      check("t3_up_lamp", 32'(bus.hall_up_lamp), 4'b0100);
      check("t3_dn_lamp", 32'(bus.hall_dn_lamp), 4'b0010);
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         wait_edges(1);
         if (bus.moving === 1'b0 && bus.door_open === 1'b0 &&
             (bus.car_call_lamp | bus.hall_up_lamp | bus.hall_dn_lamp) == '0)
            done = 1'b1;
      end
      check("t3_settled", 32'(done), 1);
      check("t3_floor", 32'(bus.floor_idx), 1);
      check("t3_dir", 32'(bus.dir_up), 0);
      check("t3_dn_cleared", 32'(bus.hall_dn_lamp), 0);

      // Ignored buttons: hall up at top floor and hall down at bottom floor.
      do_reset();
      check("t4_rst_floor", 32'(bus.floor_idx), 0);
      @(negedge clk);
      bus.hall_up_in = 4'b1000;
      bus.hall_dn_in = 4'b0001;
      wait_edges(1);
      bus.hall_up_in = '0;
      bus.hall_dn_in = '0;
      check("t4_lamps_k", {bus.car_call_lamp, bus.hall_up_lamp, bus.hall_dn_lamp}, 0);
      wait_edges(3);
      check("t4_lamps_later", {bus.car_call_lamp, bus.hall_up_lamp, bus.hall_dn_lamp}, 0);
      check("t4_door", 32'(bus.door_open), 0);
      check("t4_moving", 32'(bus.moving), 0);

      // Asynchronous reset mid-step between floors 1 and 2.
      @(negedge clk);
      bus.car_call_in = 4'b1000;
      wait_edges(1);
      bus.car_call_in = '0;
      wait_edges(6);
      check("t5_floor_pre", 32'(bus.floor_idx), 1);
      check("t5_moving_pre", 32'(bus.moving), 1);
      check("t5_lamp_pre", 32'(bus.car_call_lamp), 4'b1000);
      #1;
      rst = 1'b1;
      #1;
      check("t5_floor_rst", 32'(bus.floor_idx), 0);
      check("t5_moving_rst", 32'(bus.moving), 0);
      check("t5_lamp_rst", 32'(bus.car_call_lamp), 0);
      check("t5_dir_rst", 32'(bus.dir_up), 1);
      check("t5_door_rst", 32'(bus.door_open), 0);
      @(negedge clk);
      rst = 1'b0;
      wait_edges(3);
      check("t5_idle_after", {31'd0, bus.moving | bus.door_open}, 0);
      check("t5_floor_after", 32'(bus.floor_idx), 0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/elevator_group_ctrl.md
Name: elevator_group_ctrl

Overview:
- Parametrised N-floor elevator car controller; successor to the fixed 3-floor controller.
- Latches car calls and hall up/down calls, drives the call lamps, and runs a collective (SCAN) direction algorithm.
- Uses timed travel and door dwell, reporting position as a binary floor index.
- Sits between the button/lamp I/O layer and the car position/door indicators.

Parameters:
- NUM_FLOORS, 4: number of floors, legal range 2..16; floor 0 is the lowest.
- FLOOR_W, $clog2(NUM_FLOORS): width of the floor index.
- DOOR_CYCLES, 8: number of cycles door_open stays high per stop (≥2).
- TRAVEL_CYCLES, 4: number of cycles to move one floor (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- car_call_in  in  NUM_FLOORS  in-car floor buttons; bit f = floor f; level or pulse.
- hall_up_in  in  NUM_FLOORS  hall up buttons; bit NUM_FLOORS-1 is ignored.
- hall_dn_in  in  NUM_FLOORS  hall down buttons; bit 0 is ignored.
- floor_idx  out  FLOOR_W  current floor, binary.
- door_open  out  1  door open.
- moving  out  1  car travelling between floors.
- dir_up  out  1  current/last direction; 1 = up.
- car_call_lamp  out  NUM_FLOORS  latched car calls.
- hall_up_lamp  out  NUM_FLOORS  latched up calls.
- hall_dn_lamp  out  NUM_FLOORS  latched down calls.

Behaviour:
- Reset (asynchronous, any state, including mid-travel): state IDLE; floor_idx=0; door_open=0; moving=0; dir_up=1; all lamps 0; both timers 0.
- All outputs are registered.
- Call latching:
  - A lamp bit sets on the edge at which its input bit is sampled high.
  - Lamp bits stay set until the call is served.
  - hall_up_lamp[NUM_FLOORS-1] and hall_dn_lamp[0] are never set.
  - Simultaneous presses all latch on the same edge.
- Call absorption while DOOR_OPEN: a press at the current floor whose car call or hall call matches dir_up is not latched and reloads the door timer.
- States: IDLE, DOOR_OPEN, MOVING.
- IDLE:
  - If any lamp is set for floor_idx: go to DOOR_OPEN next edge and clear those lamps on that edge. Set dir_up toward the cleared hall call; if both hall directions are set, up wins.
  - Else if calls exist: go to MOVING next edge, moving=1.
    - dir_up points to the nearest call; equal distance picks up.
    - At floor 0, dir_up is forced to 1; at the top floor, forced to 0.
  - Else: stay in IDLE.
- MOVING:
  - Travel counter counts TRAVEL_CYCLES cycles; on expiry, floor_idx moves ±1.
  - Stop at the new floor if it has a car call, a hall call in dir_up, or no calls further ahead. On that same edge: moving=0, door_open=1, state DOOR_OPEN, and the served lamps clear (car call plus matching-direction hall call).
  - When stopping because no calls are ahead, also clear the opposite hall call and flip dir_up.
  - Otherwise reload the counter and continue.
  - floor_idx never leaves the range 0..NUM_FLOORS-1.
- DOOR_OPEN:
  - door_open stays high for exactly DOOR_CYCLES cycles (longer if reloaded by absorption).
  - On expiry, door_open=0 and the next state is:
    - calls ahead in dir_up → MOVING;
    - else calls behind → flip dir_up; if the opposite hall call at this floor is set, clear it and reload the timer (door stays open); otherwise → MOVING;
    - no calls → IDLE.
- Latency: press at an idle car's own floor at edge k gives door_open=1 at edge k+1.
- Calls latched during travel are considered at the next floor decision.

Optional Feature:
- Macro ELEVATOR_FIRE_RECALL_EN.
- When defined:
  - Adds input fire_recall (1 bit).
  - While fire_recall=1, all lamps are held clear and new presses are ignored.
  - If the car is moving, it finishes the current floor step.
  - It then travels down (dir_up=0) without intermediate stops to floor 0, opens the door, and holds door_open=1 until fire_recall=0.
  - On deassertion, the door timer reloads to DOOR_CYCLES and normal operation resumes.
- When undefined: the port is absent and the logic is not synthesised.

Test Plan (defaults: NUM_FLOORS=4, DOOR_CYCLES=8, TRAVEL_CYCLES=4):
- Reset idle, pulse car_call_in[2] sampled at edge k → car_call_lamp=0100 at k; moving=1 at k+1; floor_idx=1 at k+5; floor_idx=2, door_open=1, lamp 0000 at k+9; door_open=0 and IDLE at k+17.
- At floor 0 idle, pulse hall_up_in[0] → door_open=1 next edge, hall_up_lamp[0] cleared; door open exactly 8 cycles.
- At floor 0, car_call_in[3] pulsed; during the first travel step pulse hall_up_in[2] and hall_dn_in[1] → stops at 2 (clears up lamp), then at 3, then reverses and stops at 1 with dir_up=0, hall_dn_lamp[1] cleared.
- Pulse hall_up_in[3] and hall_dn_in[0] while idle at floor 0 → all lamps remain 0, state stays IDLE, door_open=0.
- Car moving 1→2 with car_call_lamp[3] set; assert rst for 1 cycle mid-step → immediately floor_idx=0, moving=0, lamps 0, dir_up=1.
- (ELEVATOR_FIRE_RECALL_EN) Car at floor 3 with car call 2 pending; assert fire_recall → lamps clear, car reaches floor 0 after 12 cycles with no stops, door_open held high until fire_recall drops, then high 8 more cycles.
